// File: rtl/code_entry_fsm.sv
// code_entry_fsm: collects a keypad code, checks it, tracks strikes; CODE_TIMEOUT_EN adds an idle timeout
module code_entry_fsm #(
    parameter int CODE_LEN    = 4,
    parameter int MAX_STRIKES = 3,
    parameter int TIMEOUT     = 250000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            btn_pulse,
    input  logic [2*CODE_LEN-1:0] secret,
    output logic [2:0]            digit_cnt,
    output logic                  solved,
    output logic                  strike_pulse,
    output logic [1:0]            strikes,
    output logic                  exploded
);
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, SOLVED, BOOM} state_t;
    state_t                state;
    logic [2*CODE_LEN-1:0] entry;
    logic                  valid;
    logic [1:0]            idx;
`ifdef CODE_TIMEOUT_EN
    logic [27:0]           idle_cnt;
`endif
    // a press counts only when exactly one button fired; encode its index
    always_comb begin
        valid = (btn_pulse != 4'd0) && ((btn_pulse & (btn_pulse - 4'd1)) == 4'd0);
        idx   = {btn_pulse[3] | btn_pulse[2], btn_pulse[3] | btn_pulse[1]};
    end
    // game state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            entry        <= '0;
            digit_cnt    <= 3'd0;
            solved       <= 1'b0;
            strike_pulse <= 1'b0;
            strikes      <= 2'd0;
            exploded     <= 1'b0;
`ifdef CODE_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            strike_pulse <= 1'b0;
            case (state)
                IDLE: state <= ENTRY;
                ENTRY: begin
                    if (valid) begin
                        for (int k = 0; k < CODE_LEN; k++)
                            if (digit_cnt == 3'(k)) entry[2*k +: 2] <= idx;
                        digit_cnt <= digit_cnt + 3'd1;
                        if (digit_cnt == 3'(CODE_LEN - 1)) state <= CHECK;
`ifdef CODE_TIMEOUT_EN
                        idle_cnt <= '0;
                    end else if (digit_cnt != 3'd0) begin
                        if (idle_cnt == 28'(TIMEOUT - 1)) begin
                            entry     <= '0;
                            digit_cnt <= 3'd0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 28'd1;
                        end
`endif
                    end
                end
                CHECK: begin
                    if (entry == secret) begin
                        state  <= SOLVED;
                        solved <= 1'b1;
                    end else begin
                        strike_pulse <= 1'b1;
                        strikes      <= strikes + 2'd1;
                        if (strikes + 2'd1 == 2'(MAX_STRIKES)) begin
                            state    <= BOOM;
                            exploded <= 1'b1;
                        end else begin
                            state     <= ENTRY;
                            entry     <= '0;
                            digit_cnt <= 3'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
